// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory system for the CPU memory stage.
// Holds a word-addressed data RAM with read-first behaviour and a memory-mapped
// 8N1 UART transmitter fed by a TX FIFO. Every read is free of side effects and
// returns registered data one cycle after the address is presented.
// Optional feature macro: DMEM_MMIO_CYCLE_COUNTER_EN adds a 32-bit free-running
// cycle counter readable at 0x8000_0008 (reads 0 when the macro is undefined).
module dmem_mmio #(
  parameter int DMEM_WORDS = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Address decode; the byte offset bits never take part in a word access
  logic          is_io;
  logic          sel_txdata;
  logic          sel_status;
  logic          sel_cycles;
  logic [AW-1:0] ram_idx;
  logic          unused_addr;

  assign is_io       = mem_addr[31];
  assign sel_txdata  = (mem_addr[31:2] == 30'h2000_0000);
  assign sel_status  = (mem_addr[31:2] == 30'h2000_0001);
  assign sel_cycles  = (mem_addr[31:2] == 30'h2000_0002);
  assign ram_idx     = mem_addr[AW+1:2];
  assign unused_addr = ^mem_addr[1:0];

  logic [31:0] ram [DMEM_WORDS];

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  tx_state_t     state;
  tx_state_t     state_n;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          tx_n;
  logic          div_done;

  logic          busy;
  logic [4:0]    count5;
  logic [31:0]   status_w;
  logic [31:0]   cycles_w;
  logic [31:0]   rd_p0;

  // RAM store lands on the clock edge; contents are never reset
  always_ff @(posedge clk) begin
    if (mem_write && !is_io) begin
      ram[ram_idx] <= mem_wdata;
    end
  end

  assign push_req = mem_write && sel_txdata;
  assign full     = (count == DEPTH_C);
  assign push_ok  = push_req && !full;

  // FIFO storage; accepted pushes only
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full) begin
        overflow <= 1'b1;
      end else if (mem_write && sel_status) begin
        overflow <= 1'b0;
      end
    end
  end

  assign div_done = (div_cnt == DIV_LAST);

  // Transmitter next-state, bit timing and the value uart_tx takes next cycle
  always_comb begin
    state_n = state;
    div_n   = div_cnt + DW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (div_done) begin
          state_n = DATA;
          div_n   = '0;
          bit_n   = 3'd0;
        end
      end
      DATA: begin
        if (div_done) begin
          shift_n = {1'b0, shift[7:1]};
          div_n   = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (div_done) begin
          state_n = IDLE;
          div_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
      end
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // Transmitter control registers and the registered serial line
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= 3'd0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_idx <= bit_n;
      uart_tx <= tx_n;
    end
  end

  // Transmit shift register (data only, loaded on pop)
  always_ff @(posedge clk) begin
    shift <= shift_n;
  end

`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycles;

  // Free-running cycle counter, wraps at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  assign cycles_w = cycles;
`else
  assign cycles_w = '0;
`endif

  assign busy     = (count != '0) || (state != IDLE);
  assign count5   = 5'(count);
  assign status_w = {24'd0, count5, overflow, full, busy};

  // Read mux: RAM is read before any same-cycle store, registers reflect current state
  always_comb begin
    rd_p0 = '0;
    if (!is_io) begin
      rd_p0 = ram[ram_idx];
    end else if (sel_status) begin
      rd_p0 = status_w;
    end else if (sel_cycles) begin
      rd_p0 = cycles_w;
    end
  end

  // p0 -> p1: registered read data to the writeback stage
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata <= '0;
    end else begin
      mem_rdata <= rd_p0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio with CLK_DIV=4, FIFO_DEPTH=8.
// Read expectations are queued as each bus cycle is driven and compared when
// the registered read data appears one cycle later.
module tb_dmem_mmio;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;
  localparam logic [31:0] A_UNM = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        uart_tx;

  int n_chk = 0;
  int n_bad = 0;

  logic [32:0] q_exp [$];
  string       q_tag [$];
  logic [31:0] cyc_model;

  always #5 clk = ~clk;

  dmem_mmio #(
    .DMEM_WORDS(1024),
    .FIFO_DEPTH(8),
    .CLK_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .uart_tx(uart_tx)
  );

  // Reference cycle counter: value held during a cycle equals what a CYCLES read returns
  always @(posedge clk) begin
    if (reset) cyc_model <= 32'd0;
    else       cyc_model <= cyc_model + 32'd1;
  end

  function automatic logic [31:0] cyc_exp();
`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
    return cyc_model;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h want=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle; the queued expectation is checked after the edge
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic chk_en, input logic [31:0] e, input string tag);
    logic [32:0] x;
    string       t;
    mem_addr  = a;
    mem_wdata = d;
    mem_write = we;
    q_exp.push_back({chk_en, e});
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    x = q_exp.pop_front();
    t = q_tag.pop_front();
    if (x[32]) chk(t, mem_rdata, x[31:0]);
    mem_write = 1'b0;
  endtask

  task automatic idle();
    bus(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] byte_v;
    logic       exp_bit;
    reset     = 1'b1;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    reset = 1'b0;

    // Reset state of registers and the cycle counter
    bus(A_ST, 0, 1'b0, 1'b1, 32'h0, "rst_status");
    bus(A_CYC, 0, 1'b0, 1'b1, cyc_exp(), "cycles_a");
    repeat (4) idle();
    bus(A_CYC, 0, 1'b0, 1'b1, cyc_exp(), "cycles_b");

    // RAM: store, read back, read-first, aliasing
    bus(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, "");
    bus(32'h10, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, "ram_rd");
    bus(32'h10, 32'h1, 1'b1, 1'b1, 32'hDEAD_BEEF, "ram_rdfirst");
    bus(32'h10, 0, 1'b0, 1'b1, 32'h1, "ram_new");
    bus(32'h1010, 0, 1'b0, 1'b1, 32'h1, "ram_alias");
    bus(32'h100, 32'h1234_5678, 1'b1, 1'b0, 32'h0, "");

    // Unmapped space reads 0 and ignores stores
    bus(A_UNM, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, "unm_wr");
    bus(A_UNM, 0, 1'b0, 1'b1, 32'h0, "unm_rd");
    bus(32'h100, 0, 1'b0, 1'b1, 32'h1234_5678, "unm_ram_kept");
    bus(A_ST, 0, 1'b0, 1'b1, 32'h0, "unm_status_kept");
    bus(A_TX, 0, 1'b0, 1'b1, 32'h0, "txdata_rd");

    // Single byte frame
    byte_v = 8'hA5;
    bus(A_TX, {24'd0, byte_v}, 1'b1, 1'b0, 32'h0, "");
    chk("tx_pre", {31'd0, uart_tx}, 32'd1);
    bus(A_ST, 0, 1'b0, 1'b1, 32'h9, "st_count1");
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       exp_bit = 1'b0;
      else if (k < 36) exp_bit = byte_v[(k - 4) / 4];
      else             exp_bit = 1'b1;
      chk($sformatf("tx_k%0d", k), {31'd0, uart_tx}, {31'd0, exp_bit});
      bus((k == 20) ? A_ST : 32'h0, 0, 1'b0, (k == 20), 32'h1, "st_busy");
    end
    chk("tx_idle", {31'd0, uart_tx}, 32'd1);
    bus(A_ST, 0, 1'b0, 1'b1, 32'h0, "st_done");

    // Overflow: ten pushes, one popped, eight stored, last dropped
    for (int i = 0; i < 10; i++) begin
      bus(A_TX, 32'h30 + i, 1'b1, 1'b0, 32'h0, "");
    end
    bus(A_ST, 0, 1'b0, 1'b1, 32'h47, "st_ovf");
    bus(A_ST, 0, 1'b1, 1'b1, 32'h47, "st_clr_rd");
    bus(A_ST, 0, 1'b0, 1'b1, 32'h43, "st_cleared");

    // Reset mid-frame (transmitter is in DATA here)
    reset = 1'b1;
    bus(A_ST, 0, 1'b0, 1'b1, 32'h0, "rst_mid_rdata");
    reset = 1'b0;
    chk("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus(A_ST, 0, 1'b0, 1'b1, 32'h0, "rst_mid_status");
      chk("rst_mid_tx_hold", {31'd0, uart_tx}, 32'd1);
    end
    bus(32'h10, 0, 1'b0, 1'b1, 32'h1, "ram_survives_rst");
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
